tach_window_controller: RTL and testbench

Sequencer for the encoder-clocked pulse tachometer. It runs a measurement cycle repeatedly: reset the counter, open a fixed gate window, close it, then wait for the counter's capture. It synchronises the tachometer's encoder-domain outputs into the system clock domain and scales the captured pulse count to RPM. Each result is delivered to the processor interface through a valid/ready handshake. It sits between the tachometer and the register/bus block, and it is the only driver of `timer_reset` and `timer_on`.

---
 rtl/tach_pkg.sv | 17 +
 rtl/sync_bit.sv | 23 ++
 rtl/tach_window_controller.sv | 149 ++++++++++++++
 tb/tb_tach_window_controller.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tach_pkg.sv
// rtl/tach_pkg.sv - shared types and widths for the tachometer window sequencer
package tach_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        COUNT,
        CLOSE,
        SETTLE,
        REPORT
    } tach_state_t;

    localparam int TACH_SETTLE_CYCLES = 2;
    localparam int TACH_COUNT_W       = 32;
    localparam int TACH_SCALE_W       = 16;

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - single-bit multi-flop synchroniser into the clk domain
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/tach_window_controller.sv
// rtl/tach_window_controller.sv - gate-window sequencer, capture and RPM scaling for the pulse tachometer
module tach_window_controller
    import tach_pkg::*;
#(
    parameter int                      WINDOW_CYCLES  = 5_000_000,
    parameter int                      TIMEOUT_CYCLES = 10_000_000,
    parameter logic [TACH_SCALE_W-1:0] RPM_SCALE      = 16'd400,
    parameter int                      SYNC_STAGES    = 2
) (
    input  logic                    clk,
    input  logic                    system_reset,
    input  logic                    enable,
    output logic                    timer_reset,
    output logic                    timer_on,
    input  logic                    tachometer_ready,
    input  logic [TACH_COUNT_W-1:0] tach_count,
    output logic                    sample_valid,
    input  logic                    sample_ready,
    output logic [TACH_COUNT_W-1:0] pulse_count,
    output logic [TACH_COUNT_W-1:0] rpm,
    output logic                    stalled
);

    localparam int MAX_LOAD = (WINDOW_CYCLES > TIMEOUT_CYCLES) ? WINDOW_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W    = $clog2(MAX_LOAD + 1);
    localparam int PROD_W   = TACH_COUNT_W + TACH_SCALE_W;

    localparam logic [PROD_W-1:0] SCALE_EXT = {{TACH_COUNT_W{1'b0}}, RPM_SCALE};

    tach_state_t        state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               ready_sync;
    logic               capture, timeout;
    logic [PROD_W-1:0]  product;
    logic [TACH_COUNT_W-1:0] rpm_next;

    sync_bit #(
        .STAGES(SYNC_STAGES)
    ) u_ready_sync (
        .clk  (clk),
        .rst_n(system_reset),
        .d    (tachometer_ready),
        .q    (ready_sync)
    );

    // Every state entry reloads the shared down-counter with that state's budget.
    function automatic logic [CNT_W-1:0] load_for(input tach_state_t s);
        case (s)
            COUNT:        return CNT_W'(WINDOW_CYCLES - 1);
            CLEAR, CLOSE: return CNT_W'(TIMEOUT_CYCLES - 1);
            SETTLE:       return CNT_W'(TACH_SETTLE_CYCLES - 1);
            default:      return '0;
        endcase
    endfunction

    always_comb begin
        state_d = state;
        capture = 1'b0;
        timeout = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_d = CLEAR;
            end
            CLEAR: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (ready_sync) begin
                    state_d = COUNT;
                end else if (cnt == '0) begin
                    timeout = 1'b1;
                    state_d = REPORT;
                end
            end
            COUNT: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (cnt == '0) begin
                    state_d = CLOSE;
                end
            end
            CLOSE: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (!ready_sync) begin
                    state_d = SETTLE;
                end else if (cnt == '0) begin
                    timeout = 1'b1;
                    state_d = REPORT;
                end
            end
            SETTLE: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (cnt == '0) begin
                    capture = 1'b1;
                    state_d = REPORT;
                end
            end
            REPORT: begin
                if (sample_valid && sample_ready) state_d = enable ? CLEAR : IDLE;
            end
            default: state_d = IDLE;
        endcase

        cnt_d = cnt;
        if (state_d != state) begin
            cnt_d = load_for(state_d);
        end else if (cnt != '0) begin
            cnt_d = cnt - 1'b1;
        end
    end

    assign product  = {{TACH_SCALE_W{1'b0}}, tach_count} * SCALE_EXT;
    assign rpm_next = (|product[PROD_W-1:TACH_COUNT_W]) ? '1 : product[TACH_COUNT_W-1:0];

    // Control outputs are registered from the next state so they align with the state register.
    always_ff @(posedge clk or negedge system_reset) begin
        if (!system_reset) begin
            state        <= IDLE;
            cnt          <= '0;
            timer_reset  <= 1'b1;
            timer_on     <= 1'b0;
            sample_valid <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            timer_reset  <= (state_d == IDLE) || (state_d == CLEAR);
            timer_on     <= (state_d == COUNT);
            sample_valid <= (state_d == REPORT);
        end
    end

    always_ff @(posedge clk or negedge system_reset) begin
        if (!system_reset) begin
            pulse_count <= '0;
            rpm         <= '0;
            stalled     <= 1'b0;
        end else if (capture) begin
            pulse_count <= tach_count;
            rpm         <= rpm_next;
            stalled     <= 1'b0;
        end else if (timeout) begin
            pulse_count <= '0;
            rpm         <= '0;
            stalled     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tach_window_controller.sv
// tb/tb_tach_window_controller.sv - scoreboard bench with a behavioural encoder-clocked tachometer
module tb_tach_window_controller;

    localparam int WIN   = 100;
    localparam int TMO   = 300;
    localparam int SCALE = 400;

    logic        clk = 1'b0;
    logic        system_reset;
    logic        enable;
    logic        timer_reset;
    logic        timer_on;
    logic        tachometer_ready;
    logic [31:0] tach_count;
    logic        sample_valid;
    logic        sample_ready;
    logic [31:0] pulse_count;
    logic [31:0] rpm;
    logic        stalled;

    always #5 clk = ~clk;

    tach_window_controller #(
        .WINDOW_CYCLES (WIN),
        .TIMEOUT_CYCLES(TMO),
        .RPM_SCALE     (16'd400),
        .SYNC_STAGES   (2)
    ) dut (
        .clk             (clk),
        .system_reset    (system_reset),
        .enable          (enable),
        .timer_reset     (timer_reset),
        .timer_on        (timer_on),
        .tachometer_ready(tachometer_ready),
        .tach_count      (tach_count),
        .sample_valid    (sample_valid),
        .sample_ready    (sample_ready),
        .pulse_count     (pulse_count),
        .rpm             (rpm),
        .stalled         (stalled)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rpm;
        logic        st;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          checks   = 0;
    int          failures = 0;
    int          n_popped = 0;
    logic        enc_run  = 1'b0;
    logic        force_en = 1'b0;
    logic [31:0] force_val = '0;
    logic [31:0] m_cnt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sat_rpm(input logic [31:0] c);
        logic [63:0] p;
        p = 64'(c) * 64'(SCALE);
        return (p > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : p[31:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_on(input string name);
        int n;
        n = 0;
        while (timer_on !== 1'b1 && n < 1000) begin
            step();
            n++;
        end
        check(name, 32'(timer_on), 32'd1);
    endtask

    task automatic measure_window(input string name);
        int w;
        w = 0;
        wait_on({name, "_rise"});
        while (timer_on === 1'b1 && w < 1000) begin
            step();
            w++;
        end
        check(name, w, WIN);
    endtask

    task automatic wait_pops(input int target, input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (n_popped < target && n < 3000);
        check(name, 32'(n_popped >= target), 32'd1);
        #1;
    endtask

    // Tachometer model: clears on timer_reset, counts while gated, latches once the gate closes.
    initial begin
        tachometer_ready = 1'b0;
        tach_count       = '0;
        forever begin
            repeat (10) @(posedge clk);
            #3;
            if (enc_run) begin
                if (timer_reset) begin
                    m_cnt            = '0;
                    tachometer_ready = 1'b1;
                end else if (timer_on) begin
                    m_cnt = m_cnt + 1;
                end else if (tachometer_ready) begin
                    tach_count = force_en ? force_val : m_cnt;
                    if (!force_en) sb_q.push_back('{m_cnt, sat_rpm(m_cnt), 1'b0});
                    tachometer_ready = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (system_reset === 1'b1 && sample_valid === 1'b1 && sample_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_sample: got pulse_count 0x%08h stalled %0b with none expected",
                         pulse_count, stalled);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_pulse_count", pulse_count, mon_e.pc);
                check("sb_rpm", rpm, mon_e.rpm);
                check("sb_stalled", 32'(stalled), 32'(mon_e.st));
                n_popped++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

    logic [31:0] force_tab[3];
    logic [31:0] rpm_tab[3];

    initial begin
        int c;
        int bad;
        force_tab[0] = 32'h00A3_D70A; rpm_tab[0] = 32'hFFFF_FFA0;
        force_tab[1] = 32'h00A3_D70B; rpm_tab[1] = 32'hFFFF_FFFF;
        force_tab[2] = 32'h00FF_FFFF; rpm_tab[2] = 32'hFFFF_FFFF;

        system_reset = 1'b0;
        enable       = 1'b0;
        sample_ready = 1'b1;
        enc_run      = 1'b1;
        repeat (3) step();
        check("rst_timer_reset", 32'(timer_reset), 32'd1);
        check("rst_timer_on", 32'(timer_on), 32'd0);
        check("rst_sample_valid", 32'(sample_valid), 32'd0);
        check("rst_pulse_count", pulse_count, 32'd0);
        check("rst_rpm", rpm, 32'd0);
        check("rst_stalled", 32'(stalled), 32'd0);
        system_reset = 1'b1;
        repeat (15) step();

        // Two back-to-back normal measurements: 10 encoder edges per 100-cycle window.
        enable = 1'b1;
        measure_window("window_len");
        wait_pops(2, "normal_pops");
        enable = 1'b0;
        repeat (15) step();

        // Encoder stops inside the window: CLOSE times out after TMO cycles.
        enable = 1'b1;
        wait_on("stall_on_rise");
        enc_run = 1'b0;
        sb_q.push_back('{32'd0, 32'd0, 1'b1});
        c = 0;
        while (timer_on === 1'b1 && c < 1000) begin
            step();
            c++;
        end
        c = 0;
        while (sample_valid !== 1'b1 && c < 1000) begin
            step();
            c++;
        end
        check("stall_close_cycles", c, TMO);
        wait_pops(3, "stall_pops");
        enable  = 1'b0;
        enc_run = 1'b1;
        repeat (15) step();

        // Forced counts around the 32-bit saturation boundary.
        force_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            force_val = force_tab[i];
            sb_q.push_back('{force_tab[i], rpm_tab[i], 1'b0});
            enable = 1'b1;
            wait_pops(4 + i, "force_pops");
            enable = 1'b0;
            repeat (15) step();
        end
        force_en = 1'b0;

        // Consumer stalls for 500 cycles; result must hold and no new window may open.
        sample_ready = 1'b0;
        enable       = 1'b1;
        c = 0;
        while (sample_valid !== 1'b1 && c < 2000) begin
            step();
            c++;
        end
        check("hold_valid_seen", 32'(sample_valid), 32'd1);
        bad = 0;
        repeat (500) begin
            @(negedge clk);
            if (sample_valid !== 1'b1 || timer_on !== 1'b0 || sb_q.size() == 0 ||
                pulse_count !== sb_q[0].pc || rpm !== sb_q[0].rpm || stalled !== sb_q[0].st)
                bad++;
        end
        check("hold_stable_errs", bad, 0);
        @(posedge clk);
        #1;
        sample_ready = 1'b1;
        wait_pops(7, "hold_pops");
        check("accept_timer_reset", 32'(timer_reset), 32'd1);
        check("accept_valid_low", 32'(sample_valid), 32'd0);
        check("accept_timer_on", 32'(timer_on), 32'd0);
        enable = 1'b0;
        repeat (15) step();

        // Enable dropped 50 cycles into the window: abort without a sample.
        enable = 1'b1;
        wait_on("abort_on_rise");
        repeat (50) step();
        enable = 1'b0;
        step();
        check("abort_timer_on", 32'(timer_on), 32'd0);
        check("abort_timer_reset", 32'(timer_reset), 32'd1);
        c = 0;
        repeat (400) begin
            @(negedge clk);
            if (sample_valid === 1'b1) c++;
        end
        check("abort_no_sample", c, 0);

        // Asynchronous reset mid-window, then a full measurement.
        enable = 1'b1;
        wait_on("reset_on_rise");
        repeat (30) step();
        #2;
        system_reset = 1'b0;
        #1;
        check("arst_timer_on", 32'(timer_on), 32'd0);
        check("arst_timer_reset", 32'(timer_reset), 32'd1);
        check("arst_sample_valid", 32'(sample_valid), 32'd0);
        check("arst_pulse_count", pulse_count, 32'd0);
        check("arst_rpm", rpm, 32'd0);
        check("arst_stalled", 32'(stalled), 32'd0);
        repeat (12) step();
        system_reset = 1'b1;
        measure_window("window_after_reset");
        wait_pops(8, "reset_pops");
        enable = 1'b0;
        repeat (15) step();

        check("total_pops", n_popped, 8);
        check("queue_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
